// File: rtl/cpu_sim_ctrl_pkg.sv
// Shared types and helpers for the simulation/bring-up run controller.
// Holds the FSM state encoding, the tohost pass code and the exit-code decode.
package cpu_sim_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    DONE
  } sim_state_t;

  localparam int TOHOST_PASS = 1;
  localparam int EXIT_W_MAX  = 64;

  // riscv-tests report (code << 1) | 1 on failure, so the real code is one bit down.
  function automatic logic [EXIT_W_MAX-1:0] decode_exit(input logic [EXIT_W_MAX-1:0] data);
    return data >> 1;
  endfunction

endpackage

// File: rtl/cpu_sim_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// clr has the same effect as reset and wins over en.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  // NOTE: clocked state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_sim_ctrl.sv
// Run controller: sequences the CPU reset, counts RUN cycles and retired
// instructions, and snoops tohost stores to latch a pass/fail/timeout verdict.
module cpu_sim_ctrl
  import cpu_sim_ctrl_pkg::*;
#(
  parameter int                RESET_CYCLES   = 4,
  parameter int                TIMEOUT_CYCLES = 1000,
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                CNT_W          = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h0000_1000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              cpu_reset_n,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              instr_retire,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [DATA_W-1:0] exit_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instret_count
);

  localparam int                HOLD_W       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(RESET_CYCLES - 1);
  localparam bit                TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  sim_state_t        state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
  logic              cpu_reset_n_next;
  logic              pass_next, fail_next, timeout_next;
  logic [DATA_W-1:0] exit_code_next;
  logic              tohost_report;
  logic              report_pass;
  logic              timeout_hit;

  // A zero write to tohost is a no-op, so only nonzero data ends the run.
  assign tohost_report = st_valid && (st_addr == TOHOST_ADDR) && (st_data != '0);
  assign report_pass   = (st_data == DATA_W'(TOHOST_PASS));
  assign timeout_hit   = TIMEOUT_EN && (cycle_count == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HOLD;
      hold_cnt    <= '0;
      cpu_reset_n <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      exit_code   <= '0;
    end else begin
      state       <= state_next;
      hold_cnt    <= hold_cnt_next;
      cpu_reset_n <= cpu_reset_n_next;
      done        <= pass_next | fail_next;
      pass        <= pass_next;
      fail        <= fail_next;
      timeout     <= timeout_next;
      exit_code   <= exit_code_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next       = state;
    hold_cnt_next    = hold_cnt;
    cpu_reset_n_next = cpu_reset_n;
    pass_next        = pass;
    fail_next        = fail;
    timeout_next     = timeout;
    exit_code_next   = exit_code;

    case (state)
      HOLD: begin
        cpu_reset_n_next = 1'b0;
        hold_cnt_next    = hold_cnt + 1'b1;
        if (hold_cnt == HOLD_LAST) begin
          state_next       = RUN;
          cpu_reset_n_next = 1'b1;
          hold_cnt_next    = '0;
        end
      end
      RUN: begin
        // The tohost check comes first so a report on the timeout edge wins.
        if (tohost_report) begin
          state_next       = DONE;
          cpu_reset_n_next = 1'b0;
          if (report_pass) begin
            pass_next      = 1'b1;
            exit_code_next = '0;
          end else begin
            fail_next      = 1'b1;
            exit_code_next = DATA_W'(decode_exit(EXIT_W_MAX'(st_data)));
          end
        end else if (timeout_hit) begin
          state_next       = DONE;
          cpu_reset_n_next = 1'b0;
          timeout_next     = 1'b1;
          fail_next        = 1'b1;
          exit_code_next   = '1;
        end
      end
      DONE: begin
        cpu_reset_n_next = 1'b0;
      end
      default: begin
        state_next       = HOLD;
        cpu_reset_n_next = 1'b0;
        hold_cnt_next    = '0;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (state == RUN),
    .clr   (state == HOLD),
    .q     (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instret_cnt (
    .clk   (clk),
    .reset (reset),
    .en    ((state == RUN) && instr_retire),
    .clr   (state == HOLD),
    .q     (instret_count)
  );

endmodule

// File: doc/cpu_sim_ctrl.md
Name: cpu_sim_ctrl

Overview:
- Synthesizable run controller that wraps the CPU for simulation and FPGA bring-up. Replaces hand-written reset and fixed-cycle-wait logic in benches.
- Sequences the CPU reset, counts cycles and retired instructions, and snoops CPU data-store writes to a tohost address to detect pass/fail.
- Flags a timeout if the program never reports.
- Sits between the bench or board reset and the cpu instance. It drives the CPU's active-low reset_n.

Parameters:
- RESET_CYCLES, 4: CPU reset hold length in clk cycles after controller reset deasserts. Must be >= 1.
- TIMEOUT_CYCLES, 1000: RUN-state cycle limit. 0 disables the timeout.
- ADDR_W, 32: store address width.
- DATA_W, 32: store data width.
- CNT_W, 32: width of the cycle and instret counters.
- TOHOST_ADDR, 32'h0000_1000: snooped tohost word address, ADDR_W wide.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high controller reset.
- cpu_reset_n  out  1  registered active-low reset driven to the cpu.
- st_valid  in  1  CPU data store occurs this cycle.
- st_addr  in  ADDR_W  store address.
- st_data  in  DATA_W  store data.
- instr_retire  in  1  one instruction retires this cycle.
- done  out  1  sticky: run has ended.
- pass  out  1  sticky: program reported success.
- fail  out  1  sticky: program reported failure, or timeout.
- timeout  out  1  sticky: TIMEOUT_CYCLES reached without a report.
- exit_code  out  DATA_W  reported code.
- cycle_count  out  CNT_W  RUN cycles elapsed.
- instret_count  out  CNT_W  instructions retired in RUN.

Behaviour:
- Reset: while reset=1 at a clk edge:
  - state is HOLD and hold_cnt is 0.
  - cpu_reset_n=0.
  - done, pass, fail, timeout are 0; exit_code, cycle_count and instret_count are 0.
- Reset mid-run in any state gives the same result at the next edge.
- FSM states: HOLD, RUN, DONE.
- HOLD:
  - cpu_reset_n=0. hold_cnt increments each edge.
  - When hold_cnt==RESET_CYCLES-1, go to RUN and set cpu_reset_n=1 at that edge.
  - cpu_reset_n therefore rises exactly RESET_CYCLES edges after the first edge with reset=0.
  - Store and retire inputs are ignored in HOLD.
- RUN counters:
  - cycle_count increments once per edge.
  - instret_count increments on edges where instr_retire=1.
  - Both saturate at all-ones and never wrap.
- RUN tohost handling: a store with st_valid=1 and st_addr==TOHOST_ADDR is a tohost store.
  - st_data==0: ignored, stay in RUN.
  - st_data==1: next state DONE, pass=1, exit_code=0.
  - Other nonzero st_data: next state DONE, fail=1, exit_code=st_data>>1 (riscv-tests convention).
  - Flags are registered: they are visible the cycle after the store.
- RUN timeout: applies when TIMEOUT_CYCLES!=0.
  - Trigger: the edge where cycle_count==TIMEOUT_CYCLES-1 with no tohost store.
  - Result: DONE with timeout=1, fail=1, exit_code=all-ones.
- Simultaneous tohost store and timeout edge: the tohost store wins and timeout stays 0.
- Non-tohost stores have no effect.
- DONE:
  - cpu_reset_n=0 (CPU held quiescent).
  - All flags, exit_code and counters are frozen.
  - All inputs are ignored.
  - Only reset leaves DONE.
- Flag invariants:
  - pass and fail are never both 1.
  - done = pass | fail.
- Outputs are registered with no combinational input-to-output paths.

Decomposition:
- Package cpu_sim_ctrl_pkg holds:
  - state enum sim_state_t {HOLD, RUN, DONE};
  - constant TOHOST_PASS=1;
  - function decode_exit(data) returning the shifted code.
- Sub-module sat_counter (parameter W; ports clk, reset, en, clr, q) saturates at all-ones. It is instantiated twice, for cycle_count and instret_count.

Test Plan:
- Default params, reset high for 3 edges then low → cpu_reset_n rises on exactly the 4th edge after release; all outputs are 0 before that.
- In RUN, retire on 7 of 10 cycles, then store 32'h1 to 32'h1000 → next cycle done=1, pass=1, exit_code=0, cycle_count=11, instret_count=7; values are unchanged 20 cycles later.
- Store 32'h0 to 32'h1000, then 32'h1 to 32'h1004, then 32'h7 to 32'h1000 → the first two are ignored; the third gives fail=1 and exit_code=3.
- TIMEOUT_CYCLES=50 with no stores → done=fail=timeout=1, exit_code=32'hFFFF_FFFF, cycle_count=50, cpu_reset_n=0.
- TIMEOUT_CYCLES=50 with store 32'h1 to 32'h1000 on the timeout edge → pass=1, timeout=0.
- CNT_W=4 with a long run → counters saturate at 15. Reset asserted in DONE → next edge restores HOLD with all outputs at 0.
